// File: rtl/sort_32_u8_unloader.sv
// rtl/sort_32_u8_unloader.sv - captures a 32-byte sorted frame and streams it out one byte per transfer
module sort_32_u8_unloader #(
    parameter bit REVERSE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vld_in,
    input  logic [7:0] din_0,
    input  logic [7:0] din_1,
    input  logic [7:0] din_2,
    input  logic [7:0] din_3,
    input  logic [7:0] din_4,
    input  logic [7:0] din_5,
    input  logic [7:0] din_6,
    input  logic [7:0] din_7,
    input  logic [7:0] din_8,
    input  logic [7:0] din_9,
    input  logic [7:0] din_10,
    input  logic [7:0] din_11,
    input  logic [7:0] din_12,
    input  logic [7:0] din_13,
    input  logic [7:0] din_14,
    input  logic [7:0] din_15,
    input  logic [7:0] din_16,
    input  logic [7:0] din_17,
    input  logic [7:0] din_18,
    input  logic [7:0] din_19,
    input  logic [7:0] din_20,
    input  logic [7:0] din_21,
    input  logic [7:0] din_22,
    input  logic [7:0] din_23,
    input  logic [7:0] din_24,
    input  logic [7:0] din_25,
    input  logic [7:0] din_26,
    input  logic [7:0] din_27,
    input  logic [7:0] din_28,
    input  logic [7:0] din_29,
    input  logic [7:0] din_30,
    input  logic [7:0] din_31,
    input  logic       m_ready,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic [4:0] m_idx,
    output logic       m_last,
    output logic       busy,
    output logic       ovf
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] mem_q [32];
    logic [7:0] mem_d [32];
    logic       ovf_q, ovf_d;
    logic [7:0] din [32];
    logic       xfer;
    logic       final_xfer;
    logic       capture;
    logic [4:0] rd_idx;

    assign din[0]  = din_0;
    assign din[1]  = din_1;
    assign din[2]  = din_2;
    assign din[3]  = din_3;
    assign din[4]  = din_4;
    assign din[5]  = din_5;
    assign din[6]  = din_6;
    assign din[7]  = din_7;
    assign din[8]  = din_8;
    assign din[9]  = din_9;
    assign din[10] = din_10;
    assign din[11] = din_11;
    assign din[12] = din_12;
    assign din[13] = din_13;
    assign din[14] = din_14;
    assign din[15] = din_15;
    assign din[16] = din_16;
    assign din[17] = din_17;
    assign din[18] = din_18;
    assign din[19] = din_19;
    assign din[20] = din_20;
    assign din[21] = din_21;
    assign din[22] = din_22;
    assign din[23] = din_23;
    assign din[24] = din_24;
    assign din[25] = din_25;
    assign din[26] = din_26;
    assign din[27] = din_27;
    assign din[28] = din_28;
    assign din[29] = din_29;
    assign din[30] = din_30;
    assign din[31] = din_31;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_d      = mem_q;
        xfer       = (state_q == SEND) && m_ready;
        final_xfer = xfer && (cnt_q == 5'd31);
        // A new frame is only taken when the buffer is free or being freed this very cycle.
        capture    = vld_in && ((state_q == IDLE) || final_xfer);
        ovf_d      = vld_in && (state_q == SEND) && !final_xfer;
        if (capture) begin
            mem_d   = din;
            cnt_d   = 5'd0;
            state_d = SEND;
        end else if (final_xfer) begin
            cnt_d   = 5'd0;
            state_d = IDLE;
        end else if (xfer) begin
            cnt_d   = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign rd_idx  = REVERSE ? (5'd31 - cnt_q) : cnt_q;
    assign m_valid = (state_q == SEND);
    assign busy    = (state_q == SEND);
    assign m_idx   = cnt_q;
    assign m_data  = m_valid ? mem_q[rd_idx] : 8'd0;
    assign m_last  = m_valid && (cnt_q == 5'd31);
    assign ovf     = ovf_q;

endmodule
